// File: rtl/adc_cb_pkg.sv
// -----------------------------------------------------------------------------
// adc_cb_pkg
// Shared definitions for the ADC circular-buffer write arbiter.
//   acq_state_t  : acquisition sequencer states (IDLE, FILL, POST, DONE)
//   *_DEFAULT    : default channel count, sample width and bank address width
// -----------------------------------------------------------------------------
package adc_cb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_POST = 2'b10,
    ST_DONE = 2'b11
  } acq_state_t;

  localparam int NCH_DEFAULT = 4;
  localparam int DW_DEFAULT  = 12;
  localparam int AW_DEFAULT  = 8;

endpackage

// File: rtl/adc_cb_write_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: grants the first requester at or after the priority
// pointer; after a grant to channel i the pointer moves to (i+1) mod NCH.
//   clk       in   clock
//   srst      in   synchronous active-high reset (pointer back to channel 0)
//   req       in   NCH request bits
//   gnt       out  one-hot grant (combinational)
//   gnt_idx   out  index of the granted channel
//   gnt_valid out  a grant is issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
  import adc_cb_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT,
  parameter int CW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           srst,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_valid
);

  logic [CW-1:0] prio_reg;
  logic [CW-1:0] cand;

  // Scan from the farthest offset down to offset 0 so the closest requester
  // to the priority pointer is the last (winning) assignment. NCH is a power
  // of two, so the CW-bit addition wraps modulo NCH for free.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = prio_reg + CW'(k);
      if (req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
    gnt = gnt_valid ? (NCH'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      prio_reg <= '0;
    end else if (gnt_valid) begin
      prio_reg <= gnt_idx + CW'(1);
    end
  end

endmodule

// File: rtl/adc_cb_write_arbiter.sv
// -----------------------------------------------------------------------------
// adc_cb_write_arbiter
// Holds one sample per ADC channel, shares a single circular-buffer write port
// round-robin, keeps per-channel wrapping write pointers and sequences an
// acquisition (arm, pre-trigger fill, post-trigger count, done).
//   sysclk     in   clock
//   RESET      in   synchronous active-high reset
//   ARM        in   start acquisition (accepted in IDLE/DONE)
//   TRIGGER    in   trigger (accepted in FILL)
//   POSTCOUNT  in   post-trigger samples per channel, latched on trigger
//   SVALID     in   per-channel sample strobe
//   SDATA      in   channel i sample at [i*DW +: DW]
//   CBDATA     out  write data
//   CBADDRESS  out  write address within the channel bank
//   CBCHAN     out  write bank (channel)
//   WENABLE    out  write strobe, one cycle per write
//   BUSY       out  acquisition in FILL or POST
//   DONE       out  acquisition complete
//   TRIGADDR   out  per-channel address of the first post-trigger sample
//   OVERRUN    out  sticky per-channel sample-loss flag (cleared by ARM)
// -----------------------------------------------------------------------------
module adc_cb_write_arbiter
  import adc_cb_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT,
  parameter int DW  = DW_DEFAULT,
  parameter int AW  = AW_DEFAULT,
  parameter int CW  = $clog2(NCH)
) (
  input  logic              sysclk,
  input  logic              RESET,
  input  logic              ARM,
  input  logic              TRIGGER,
  input  logic [AW-1:0]     POSTCOUNT,
  input  logic [NCH-1:0]    SVALID,
  input  logic [NCH*DW-1:0] SDATA,
  output logic [DW-1:0]     CBDATA,
  output logic [AW-1:0]     CBADDRESS,
  output logic [CW-1:0]     CBCHAN,
  output logic              WENABLE,
  output logic              BUSY,
  output logic              DONE,
  output logic [NCH*AW-1:0] TRIGADDR,
  output logic [NCH-1:0]    OVERRUN
);

  acq_state_t     state_reg, state_next;
  logic           arm_accept, trig_accept, post_complete, active;

  logic [NCH-1:0] pending_reg, overrun_reg;
  logic [DW-1:0]  hold_reg     [NCH];
  logic [AW-1:0]  ptr_reg      [NCH];
  logic [AW-1:0]  ptr_next     [NCH];
  logic [AW-1:0]  cnt_reg      [NCH];
  logic [AW-1:0]  trigaddr_reg [NCH];
  logic [AW-1:0]  postcount_reg;
  logic [DW-1:0]  sdata_ch     [NCH];

  logic [NCH-1:0] req, gnt;
  logic [CW-1:0]  gnt_idx;
  logic           gnt_valid;

  logic           wenable_reg, busy_reg, done_reg;
  logic [DW-1:0]  cbdata_reg;
  logic [AW-1:0]  cbaddr_reg;
  logic [CW-1:0]  cbchan_reg;

  assign active = (state_reg == ST_FILL) || (state_reg == ST_POST);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign sdata_ch[gi]              = SDATA[gi*DW +: DW];
      assign TRIGADDR[gi*AW +: AW]     = trigaddr_reg[gi];
      assign ptr_next[gi]              = ptr_reg[gi] + AW'(gnt[gi]);
      // A channel that has delivered its post-trigger quota stops requesting;
      // its held sample simply stays put.
      assign req[gi] = pending_reg[gi] &&
                       ((state_reg == ST_FILL) ||
                        ((state_reg == ST_POST) && (cnt_reg[gi] < postcount_reg)));
    end
  endgenerate

  rr_arbiter #(.NCH(NCH), .CW(CW)) u_rr (
    .clk       (sysclk),
    .srst      (RESET),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Sequencer next-state logic
  always_comb begin
    state_next    = state_reg;
    arm_accept    = 1'b0;
    trig_accept   = 1'b0;
    post_complete = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_reg[i] != postcount_reg) post_complete = 1'b0;
    end
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (ARM) begin
          state_next = ST_FILL;
          arm_accept = 1'b1;
        end
      end
      ST_FILL: begin
        if (TRIGGER) begin
          state_next  = ST_POST;
          trig_accept = 1'b1;
        end
      end
      ST_POST: begin
        if (post_complete) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (RESET) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Datapath: holding registers, pointers, counters and registered outputs
  always_ff @(posedge sysclk) begin
    if (RESET) begin
      wenable_reg   <= 1'b0;
      cbdata_reg    <= '0;
      cbaddr_reg    <= '0;
      cbchan_reg    <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      pending_reg   <= '0;
      overrun_reg   <= '0;
      postcount_reg <= '0;
      for (int i = 0; i < NCH; i++) begin
        hold_reg[i]     <= '0;
        ptr_reg[i]      <= '0;
        cnt_reg[i]      <= '0;
        trigaddr_reg[i] <= '0;
      end
    end else begin
      wenable_reg <= gnt_valid;
      if (gnt_valid) begin
        cbdata_reg <= hold_reg[gnt_idx];
        cbaddr_reg <= ptr_reg[gnt_idx];
        cbchan_reg <= gnt_idx;
      end
      busy_reg <= (state_next == ST_FILL) || (state_next == ST_POST);
      done_reg <= (state_next == ST_DONE);
      if (trig_accept) postcount_reg <= POSTCOUNT;

      for (int i = 0; i < NCH; i++) begin
        // A granted channel frees its slot this edge, so a new strobe can
        // refill it without loss.
        if (!active) begin
          pending_reg[i] <= 1'b0;
        end else if (SVALID[i] && (!pending_reg[i] || gnt[i])) begin
          hold_reg[i]    <= sdata_ch[i];
          pending_reg[i] <= 1'b1;
        end else if (SVALID[i]) begin
          overrun_reg[i] <= 1'b1;
        end else if (gnt[i]) begin
          pending_reg[i] <= 1'b0;
        end

        if (arm_accept) begin
          ptr_reg[i]      <= '0;
          cnt_reg[i]      <= '0;
          overrun_reg[i]  <= 1'b0;
          trigaddr_reg[i] <= '0;
        end else begin
          ptr_reg[i] <= ptr_next[i];
          // The write granted on the trigger edge is still pre-trigger: it
          // is not counted, and TRIGADDR points just past it.
          if (gnt[i] && (state_reg == ST_POST)) cnt_reg[i] <= cnt_reg[i] + AW'(1);
          if (trig_accept) trigaddr_reg[i] <= ptr_next[i];
        end
      end
    end
  end

  assign WENABLE   = wenable_reg;
  assign CBDATA    = cbdata_reg;
  assign CBADDRESS = cbaddr_reg;
  assign CBCHAN    = cbchan_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign OVERRUN   = overrun_reg;

endmodule
